// File: rtl/wvb_reader_pkg.sv
// rtl/wvb_reader_pkg.sv - wvb_reader header layout, frame constants, FSM states and word builders
package wvb_reader_pkg;

    localparam int HDR_W     = 80;
    localparam int LTC_LSB   = 0;
    localparam int LTC_MSB   = 47;
    localparam int START_LSB = 48;
    localparam int START_MSB = 59;
    localparam int STOP_LSB  = 60;
    localparam int STOP_MSB  = 71;
    localparam int TRIG_LSB  = 72;
    localparam int TRIG_MSB  = 73;
    localparam int CNST_BIT  = 74;
    localparam int RSV_LSB   = 75;
    localparam int RSV_MSB   = 79;

    localparam logic [7:0] SYNC_BYTE = 8'h90;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_W0,
        S_W1,
        S_W2,
        S_SAMP,
        S_CHK
    } state_t;

    // Sample count minus one; storage addresses wrap, so plain modular subtraction
    function automatic logic [11:0] hdr_n_m1(input logic [11:0] stop_addr, input logic [11:0] start_addr);
        return stop_addr - start_addr;
    endfunction

    function automatic logic [31:0] make_w0(input logic [3:0] chan, input logic cnst_run,
                                            input logic [1:0] trig_src, input logic [11:0] n_m1);
        return {SYNC_BYTE, 4'h0, chan, 1'b0, cnst_run, trig_src, n_m1};
    endfunction

    // W1 in the upper half, W2 in the lower half
    function automatic logic [63:0] make_w1_w2(input logic [47:0] ltc, input logic [4:0] rsv);
        return {ltc, 11'h0, rsv};
    endfunction

    function automatic logic [31:0] make_sample(input logic [21:0] d);
        return {10'h0, d};
    endfunction

endpackage

// File: rtl/wvb_reader_skid_fifo.sv
// rtl/wvb_reader_skid_fifo.sv - small synchronous FIFO buffering samples returned by waveform storage
module wvb_reader_skid_fifo #(
    parameter int P_WIDTH = 22,
    parameter int P_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [P_WIDTH-1:0]           wr_data,
    input  logic                         rd_en,
    output logic [P_WIDTH-1:0]           rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(P_DEPTH):0]     count
);
    localparam int AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               wr_ok;
    logic               rd_ok;

    assign full    = (count == (AW+1)'(P_DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/wvb_reader.sv
// rtl/wvb_reader.sv - waveform buffer readout framer; WVB_READER_CHKSUM_EN adds an XOR trailer word
module wvb_reader
    import wvb_reader_pkg::*;
#(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_LTC_WIDTH  = 48,
    parameter int P_RD_LATENCY = 2,
    parameter int P_SKID_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              chan_id,
    input  logic                    rd_en,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    output logic [31:0]             dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sop,
    output logic                    dout_eop,
    output logic                    busy
);
    localparam int CNT_W = $clog2(P_SKID_DEPTH) + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [P_HDR_WIDTH-1:0]  hdr_q;
    logic [3:0]              chan_q;
    logic [P_ADR_WIDTH-1:0]  n_m1;
    logic [P_ADR_WIDTH-1:0]  samp_idx;
    logic [P_ADR_WIDTH:0]    n_total;
    logic [P_ADR_WIDTH:0]    fetch_cnt;
    logic [P_ADR_WIDTH:0]    wr_cnt;
    logic [P_RD_LATENCY-1:0] req_pipe;
    logic [CNT_W-1:0]        in_flight;
    logic [CNT_W-1:0]        fifo_count;
    logic [P_DATA_WIDTH-1:0] fifo_rdata;
    logic                    fifo_wr;
    logic                    fifo_rd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fetch_phase;
    logic                    handshake;
    logic                    last_samp;
    logic                    room;
    logic [63:0]             w12;

`ifdef WVB_READER_CHKSUM_EN
    logic [31:0]             chk_acc;
`endif

    assign n_m1      = P_ADR_WIDTH'(hdr_n_m1(hdr_q[STOP_MSB:STOP_LSB], hdr_q[START_MSB:START_LSB]));
    assign n_total   = {1'b0, n_m1} + (P_ADR_WIDTH+1)'(1);
    assign w12       = make_w1_w2(hdr_q[P_LTC_WIDTH-1:0], hdr_q[RSV_MSB:RSV_LSB]);
    assign last_samp = (samp_idx == n_m1);
    assign handshake = dout_valid && dout_ready;
    assign fifo_rd   = handshake && (state == S_SAMP);
    assign fifo_wr   = req_pipe[P_RD_LATENCY-1];
    // Requests already in the storage pipeline count against FIFO space so no write is ever dropped
    assign room      = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(in_flight)) < (CNT_W+1)'(P_SKID_DEPTH);
    assign wvb_rdreq = fetch_phase && (fetch_cnt < n_total) && room && !fifo_full;

    wvb_reader_skid_fifo #(
        .P_WIDTH (P_DATA_WIDTH),
        .P_DEPTH (P_SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (wvb_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; header words advance only on an accepted word
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rd_en && !hdr_empty) state_nxt = S_HDR;
            S_HDR:  state_nxt = S_W0;
            S_W0:   if (handshake) state_nxt = S_W1;
            S_W1:   if (handshake) state_nxt = S_W2;
            S_W2:   if (handshake) state_nxt = S_SAMP;
`ifdef WVB_READER_CHKSUM_EN
            S_SAMP: if (handshake && last_samp) state_nxt = S_CHK;
            S_CHK:  if (handshake) state_nxt = S_IDLE;
`else
            S_SAMP: if (handshake && last_samp) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state only, so ready never reaches valid combinationally
    always_comb begin
        dout        = '0;
        dout_valid  = 1'b0;
        dout_sop    = 1'b0;
        dout_eop    = 1'b0;
        hdr_rdreq   = 1'b0;
        fetch_phase = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_HDR: hdr_rdreq = 1'b1;
            S_W0: begin
                dout_valid  = 1'b1;
                dout_sop    = 1'b1;
                dout        = make_w0(chan_q, hdr_q[CNST_BIT], hdr_q[TRIG_MSB:TRIG_LSB], 12'(n_m1));
                fetch_phase = 1'b1;
            end
            S_W1: begin
                dout_valid  = 1'b1;
                dout        = w12[63:32];
                fetch_phase = 1'b1;
            end
            S_W2: begin
                dout_valid  = 1'b1;
                dout        = w12[31:0];
                fetch_phase = 1'b1;
            end
            S_SAMP: begin
                fetch_phase = 1'b1;
                dout_valid  = !fifo_empty;
                if (!fifo_empty) dout = make_sample(22'(fifo_rdata));
`ifndef WVB_READER_CHKSUM_EN
                dout_eop    = !fifo_empty && last_samp;
`endif
            end
`ifdef WVB_READER_CHKSUM_EN
            S_CHK: begin
                dout_valid = 1'b1;
                dout       = chk_acc;
                dout_eop   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Header and channel capture on the pop cycle; held for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q  <= '0;
            chan_q <= '0;
        end else if (state == S_HDR) begin
            hdr_q  <= hdr_data;
            chan_q <= chan_id;
        end
    end

    // Storage read pipeline: a request's data lands P_RD_LATENCY cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pipe  <= '0;
            in_flight <= '0;
        end else begin
            req_pipe[0] <= wvb_rdreq;
            for (int i = 1; i < P_RD_LATENCY; i++) req_pipe[i] <= req_pipe[i-1];
            case ({wvb_rdreq, fifo_wr})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Per-frame counters and the buffer-release pulse after the last sample lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= '0;
            wr_cnt     <= '0;
            samp_idx   <= '0;
            wvb_rddone <= 1'b0;
        end else begin
            wvb_rddone <= fifo_wr && (wr_cnt == {1'b0, n_m1});
            if (state == S_HDR) begin
                fetch_cnt <= '0;
                wr_cnt    <= '0;
                samp_idx  <= '0;
            end else begin
                if (wvb_rdreq) fetch_cnt <= fetch_cnt + (P_ADR_WIDTH+1)'(1);
                if (fifo_wr)   wr_cnt    <= wr_cnt + (P_ADR_WIDTH+1)'(1);
                if (fifo_rd)   samp_idx  <= samp_idx + P_ADR_WIDTH'(1);
            end
        end
    end

`ifdef WVB_READER_CHKSUM_EN
    // Running XOR of every accepted word ahead of the trailer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             chk_acc <= '0;
        else if (state == S_HDR)                chk_acc <= '0;
        else if (handshake && state != S_CHK)   chk_acc <= chk_acc ^ dout;
    end
`endif

endmodule

// File: tb/tb_wvb_reader.sv
// tb/tb_wvb_reader.sv - randomized self-checking bench for wvb_reader against a frame-level model
module tb_wvb_reader;

`ifdef WVB_READER_CHKSUM_EN
    localparam int CHK_ON = 1;
`else
    localparam int CHK_ON = 0;
`endif

    typedef struct packed {
        logic [31:0] w;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  chan_id = 4'h0;
    logic        rd_en = 1'b0;
    logic [79:0] hdr_data = '0;
    logic        hdr_empty = 1'b1;
    logic        hdr_rdreq;
    logic [21:0] wvb_data = '0;
    logic        wvb_rdreq;
    logic        wvb_rddone;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_sop;
    logic        dout_eop;
    logic        busy;

    logic [21:0] wmem [0:4095];
    logic [79:0] hdr_q [$];
    exp_t        exp_q [$];
    int          ready_mode = 0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          words_seen = 0;
    int          hdr_pulses = 0;
    int          done_pulses = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    int          widx = 0;
    logic [31:0] fw [0:7];

    wvb_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chan_id    (chan_id),
        .rd_en      (rd_en),
        .hdr_data   (hdr_data),
        .hdr_empty  (hdr_empty),
        .hdr_rdreq  (hdr_rdreq),
        .wvb_data   (wvb_data),
        .wvb_rdreq  (wvb_rdreq),
        .wvb_rddone (wvb_rddone),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Queue a header and the frame it must produce, built from the frame rules
    task automatic push_hdr(input logic [11:0] sa, input logic [11:0] sp, input logic [47:0] ltc,
                            input logic [1:0] trig, input logic cr, input logic [4:0] rsv);
        int          n;
        logic [31:0] w;
        logic [31:0] x;
        exp_t        e;
        n = ((int'(sp) - int'(sa) + 4096) % 4096) + 1;
        x = '0;
        for (int i = 0; i < n + 3; i++) begin
            if (i == 0)      w = 32'h9000_0000 | (32'(chan_id) << 16) | (32'(cr) << 14) | (32'(trig) << 12) | 32'(n - 1);
            else if (i == 1) w = ltc[47:16];
            else if (i == 2) w = {ltc[15:0], 16'(rsv)};
            else             w = 32'(wmem[(int'(sa) + i - 3) % 4096]);
            x = x ^ w;
            e.w   = w;
            e.sop = (i == 0);
            e.eop = (i == n + 2) && (CHK_ON == 0);
            exp_q.push_back(e);
        end
        if (CHK_ON != 0) begin
            e.w = x; e.sop = 1'b0; e.eop = 1'b1;
            exp_q.push_back(e);
        end
        hdr_q.push_back({rsv, cr, trig, sp, sa, ltc});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || hdr_q.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 64'(k < budget), 64'd1);
    endtask

    // Header FIFO and waveform storage model; reacts to pops/requests seen mid-cycle
    initial begin
        logic        pop_now;
        logic        req_now;
        logic [79:0] h;
        logic [21:0] d1;
        logic [21:0] d2;
        logic [11:0] rd_addr;
        d1 = '0; d2 = '0; rd_addr = '0;
        forever begin
            @(negedge clk);
            pop_now = hdr_rdreq;
            req_now = wvb_rdreq;
            @(posedge clk); #1;
            if (!rst_n) begin
                d1 = '0; d2 = '0;
            end else begin
                if (pop_now && hdr_q.size() > 0) begin
                    h = hdr_q.pop_front();
                    rd_addr = h[59:48];
                end
                d2 = d1;
                d1 = req_now ? wmem[rd_addr] : 22'h0;
                if (req_now) rd_addr = rd_addr + 12'd1;
            end
            wvb_data  = d2;
            hdr_empty = (hdr_q.size() == 0);
            hdr_data  = hdr_empty ? 80'h0 : hdr_q[0];
            case (ready_mode)
                1:       dout_ready = ~dout_ready;
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: word-by-word scoreboard, stall stability, W0 latency, pulse counts
    initial begin
        logic        pop_prev;
        logic        stall_pend;
        logic [33:0] stall_val;
        exp_t        e;
        pop_prev = 1'b0; stall_pend = 1'b0; stall_val = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pop_prev = 1'b0;
                stall_pend = 1'b0;
            end else begin
                if (pop_prev) check_eq("w0_latency", {dout_valid, dout_sop}, 2'b11);
                if (stall_pend) check_eq("stall_hold", {dout_valid, dout_sop, dout_eop, dout}, {1'b1, stall_val});
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("frame_word", {dout_sop, dout_eop, dout}, {e.sop, e.eop, e.w});
                    end
                    if (dout_sop) begin sop_cyc = cyc; widx = 0; end
                    if (widx < 8) fw[widx] = dout;
                    widx++;
                    if (dout_eop) eop_cyc = cyc;
                    words_seen++;
                end
                stall_pend = dout_valid && !dout_ready;
                stall_val  = {dout_sop, dout_eop, dout};
                pop_prev   = hdr_rdreq;
                if (hdr_rdreq) hdr_pulses++;
                if (wvb_rddone) done_pulses++;
            end
        end
    end

    initial begin
        int          h0;
        int          d0;
        int          w0s;
        int          len;
        logic [11:0] sa;

        for (int i = 0; i < 4096; i++) wmem[i] = 22'($urandom);

        // Reset state
        #12;
        check_eq("reset_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, busy, dout},
                 39'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd_en = 1'b1;
        @(posedge clk); #1;

        // Directed frame with known header fields, ready held high
        h0 = hdr_pulses; d0 = done_pulses;
        chan_id = 4'h0; ready_mode = 0;
        push_hdr(12'h010, 12'h013, 48'h0123_4567_89AB, 2'b00, 1'b0, 5'h0);
        wait_drain("t1_drain", 200);
        check_eq("t1_w0", fw[0], 32'h9000_0003);
        check_eq("t1_w1", fw[1], 32'h0123_4567);
        check_eq("t1_w2", fw[2], 32'h89AB_0000);
        check_eq("t1_no_bubble", 64'(eop_cyc - sop_cyc), 64'(4 + 2 + CHK_ON));
        check_eq("t1_hdr_pulses", 64'(hdr_pulses - h0), 64'd1);
        check_eq("t1_done_pulses", 64'(done_pulses - d0), 64'd1);

        // Address wrap-around
        d0 = done_pulses;
        chan_id = 4'($urandom);
        push_hdr(12'hFFE, 12'h001, {16'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t2_drain", 200);
        check_eq("t2_done_pulses", 64'(done_pulses - d0), 64'd1);

        // 64-sample frame with ready toggling every cycle
        d0 = done_pulses;
        ready_mode = 1;
        push_hdr(12'h200, 12'h23F, {16'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t3_drain", 2000);
        check_eq("t3_done_pulses", 64'(done_pulses - d0), 64'd1);

        // Long frame at full rate: zero bubbles
        ready_mode = 0;
        push_hdr(12'h400, 12'h427, {16'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t4_drain", 500);
        check_eq("t4_no_bubble", 64'(eop_cyc - sop_cyc), 64'(40 + 2 + CHK_ON));

        // Two headers queued back to back, random backpressure
        h0 = hdr_pulses; d0 = done_pulses;
        ready_mode = 2;
        chan_id = 4'($urandom);
        push_hdr(12'($urandom), 12'($urandom_range(0, 4095)) , 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        check_eq("t5_queued", 64'(hdr_q.size()), 64'd1);
        hdr_q.delete();
        exp_q.delete();
        sa = 12'($urandom);
        push_hdr(sa, sa + 12'd9, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        sa = 12'($urandom);
        push_hdr(sa, sa + 12'd20, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t5_drain", 1000);
        check_eq("t5_hdr_pulses", 64'(hdr_pulses - h0), 64'd2);
        check_eq("t5_done_pulses", 64'(done_pulses - d0), 64'd2);

        // rd_en low holds off a queued header; dropping it mid-frame still completes the frame
        h0 = hdr_pulses; d0 = done_pulses;
        rd_en = 1'b0; ready_mode = 0;
        push_hdr(12'h300, 12'h30F, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        repeat (20) @(posedge clk);
        #1;
        check_eq("t6_idle_busy", 64'(busy), 64'd0);
        check_eq("t6_idle_pops", 64'(hdr_pulses - h0), 64'd0);
        w0s = words_seen;
        rd_en = 1'b1;
        for (int k = 0; k < 50 && words_seen == w0s; k++) begin @(posedge clk); #1; end
        rd_en = 1'b0;
        wait_drain("t6_drain", 300);
        check_eq("t6_done_pulses", 64'(done_pulses - d0), 64'd1);
        rd_en = 1'b1;

        // Single-sample frame with all-ones sample
        wmem[12'h100] = 22'h3FFFFF;
        ready_mode = 0;
        push_hdr(12'h100, 12'h100, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t7_drain", 200);
        check_eq("t7_len", 64'(eop_cyc - sop_cyc), 64'(1 + 2 + CHK_ON));

        // Random frames with random backpressure
        for (int f = 0; f < 6; f++) begin
            d0 = done_pulses;
            ready_mode = 2;
            chan_id = 4'($urandom);
            len = $urandom_range(1, 40);
            sa = 12'($urandom);
            push_hdr(sa, sa + 12'(len - 1), {16'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom), 5'($urandom));
            wait_drain("rand_drain", 1000);
            check_eq("rand_done_pulses", 64'(done_pulses - d0), 64'd1);
        end

        // Reset during sample phase of a 16-sample frame
        ready_mode = 0;
        w0s = words_seen;
        push_hdr(12'h500, 12'h50F, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        for (int k = 0; k < 200 && words_seen < w0s + 6; k++) begin @(posedge clk); #1; end
        check_eq("t8_reached_samp", 64'(words_seen >= w0s + 6), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("t8_reset_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, busy, dout},
                 39'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        h0 = hdr_pulses;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t8_stay_idle", {busy, dout_valid}, 2'b00);
        check_eq("t8_no_pop", 64'(hdr_pulses - h0), 64'd0);

        // Fresh frame after reset resynchronises
        d0 = done_pulses;
        push_hdr(12'h600, 12'h607, 48'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
        wait_drain("t9_drain", 200);
        check_eq("t9_done_pulses", 64'(done_pulses - d0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
